// File: rtl/mano_ac_unit.sv
// mano_ac_unit: accumulator / E-flag stage that sits directly behind the Mano ALU.
//   Owns AC and E, feeds them back to the ALU (alu_b / alu_e_in), drives a registered
//   ALU function code and captures alu_z / alu_e_out under a function-dependent write mask.
//   Also performs AC-local ops (INC_AC, CLR_AC, CLR_E) and exposes skip flags to the sequencer.
// Latency: ALU_WB accepted at edge T writes AC/E at T+2, cmd_done high the cycle after T+2;
//   local ops write at T, cmd_done high the cycle after T.
// Backpressure: cmd_ready is high only in IDLE and not during reset; a command is taken on
//   an edge with cmd_valid && cmd_ready, and cmd_op/cmd_func are sampled only then.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   cmd_valid/ready/op/func  command handshake (op 0=ALU_WB 1=INC_AC 2=CLR_AC 3=CLR_E)
//   cmd_done                 one-cycle completion pulse
//   alu_func/alu_b/alu_e_in  to the ALU;  alu_z/alu_e_out from the ALU
//   ac, e                    register values;  ac_zero, ac_neg, e_zero skip flags
//   parity_err               sticky AC integrity fault (only with AC_PARITY_EN)
// ALU function codes: AND=0 ADD=1 PASSDR=2 CMA=3 CIR=4 CIL=5 CME=6 PASSB=7 NO_FUNC=all ones;
//   any other code is treated like NO_FUNC (nothing written, cmd_done still pulses).
// Build option: define AC_PARITY_EN to add the stored-parity check on AC.
module mano_ac_unit #(
  parameter int DATAWIDTH = 16,
  parameter int FUNCWIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [FUNCWIDTH-1:0] cmd_func,
  output logic                 cmd_done,
  output logic [FUNCWIDTH-1:0] alu_func,
  output logic [DATAWIDTH-1:0] alu_b,
  output logic                 alu_e_in,
  input  logic [DATAWIDTH-1:0] alu_z,
  input  logic                 alu_e_out,
  output logic [DATAWIDTH-1:0] ac,
  output logic                 e,
  output logic                 ac_zero,
  output logic                 ac_neg,
  output logic                 e_zero,
  output logic                 parity_err
);

  localparam logic [1:0] OP_ALU_WB = 2'd0;
  localparam logic [1:0] OP_INC_AC = 2'd1;
  localparam logic [1:0] OP_CLR_AC = 2'd2;
  localparam logic [1:0] OP_CLR_E  = 2'd3;

  localparam logic [FUNCWIDTH-1:0] F_AND     = FUNCWIDTH'(0);
  localparam logic [FUNCWIDTH-1:0] F_ADD     = FUNCWIDTH'(1);
  localparam logic [FUNCWIDTH-1:0] F_PASSDR  = FUNCWIDTH'(2);
  localparam logic [FUNCWIDTH-1:0] F_CMA     = FUNCWIDTH'(3);
  localparam logic [FUNCWIDTH-1:0] F_CIR     = FUNCWIDTH'(4);
  localparam logic [FUNCWIDTH-1:0] F_CIL     = FUNCWIDTH'(5);
  localparam logic [FUNCWIDTH-1:0] F_CME     = FUNCWIDTH'(6);
  localparam logic [FUNCWIDTH-1:0] F_PASSB   = FUNCWIDTH'(7);
  localparam logic [FUNCWIDTH-1:0] F_NO_FUNC = {FUNCWIDTH{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE} state_t;

  state_t                 state_q, state_d;
  logic [FUNCWIDTH-1:0]   alu_func_q, alu_func_d;
  logic [DATAWIDTH-1:0]   ac_q, ac_d;
  logic                   e_q, e_d;
  logic                   done_q, done_d;
  logic                   accept;

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d    = state_q;
    alu_func_d = alu_func_q;
    ac_d       = ac_q;
    e_d        = e_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_ALU_WB: begin
              alu_func_d = cmd_func;
              state_d    = S_ISSUE;
            end
            OP_INC_AC: begin
              ac_d   = ac_q + DATAWIDTH'(1);
              done_d = 1'b1;
            end
            OP_CLR_AC: begin
              ac_d   = '0;
              done_d = 1'b1;
            end
            default: begin
              e_d    = 1'b0;
              done_d = 1'b1;
            end
          endcase
        end
      end
      // Function already on the bus; this cycle only lets the ALU settle.
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        case (alu_func_q)
          F_CIL, F_CIR, F_ADD: begin
            ac_d = alu_z;
            e_d  = alu_e_out;
          end
          F_CMA, F_PASSB, F_PASSDR, F_AND: ac_d = alu_z;
          F_CME:                           e_d  = alu_e_out;
          default: ;
        endcase
        done_d     = 1'b1;
        alu_func_d = F_NO_FUNC;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      alu_func_q <= F_NO_FUNC;
      ac_q       <= '0;
      e_q        <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_func_q <= alu_func_d;
      ac_q       <= ac_d;
      e_q        <= e_d;
      done_q     <= done_d;
    end
  end

`ifdef AC_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
  logic clr_ac_acc;

  assign clr_ac_acc = (state_q == S_IDLE) && accept && (cmd_op == OP_CLR_AC);

  always_comb begin
    // Rewriting AC with its current value cannot change parity, so only
    // real changes refresh the stored bit; a corrupted AC is never "blessed".
    par_d  = (ac_d != ac_q) ? ^ac_d : par_q;
    perr_d = perr_q || ((^ac_q) != par_q);
    if (clr_ac_acc) perr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign cmd_done = done_q;
  assign alu_func = alu_func_q;
  assign alu_b    = ac_q;
  assign alu_e_in = e_q;
  assign ac       = ac_q;
  assign e        = e_q;
  assign ac_zero  = (ac_q == '0);
  assign ac_neg   = ac_q[DATAWIDTH-1];
  assign e_zero   = !e_q;

endmodule

// File: tb/tb_mano_ac_unit.sv
module tb_mano_ac_unit;

  localparam int F_AND = 0, F_ADD = 1, F_PASSDR = 2, F_CMA = 3, F_CIR = 4,
                 F_CIL = 5, F_CME = 6, F_PASSB = 7, F_NO_FUNC = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_func;
  logic        cmd_done;
  logic [3:0]  alu_func;
  logic [15:0] alu_b;
  logic        alu_e_in;
  logic [15:0] alu_z;
  logic        alu_e_out;
  logic [15:0] ac;
  logic        e;
  logic        ac_zero, ac_neg, e_zero, parity_err;

  logic [15:0] dr;
  logic [15:0] junk_z;
  logic        junk_e;

  int total = 0;
  int bad   = 0;
  int m_ac;
  int m_e;

  always #5 clk = ~clk;

  mano_ac_unit #(.DATAWIDTH(16), .FUNCWIDTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_func(cmd_func), .cmd_done(cmd_done),
    .alu_func(alu_func), .alu_b(alu_b), .alu_e_in(alu_e_in),
    .alu_z(alu_z), .alu_e_out(alu_e_out), .ac(ac), .e(e),
    .ac_zero(ac_zero), .ac_neg(ac_neg), .e_zero(e_zero), .parity_err(parity_err)
  );

  // Environment ALU. Outputs the unit must ignore carry junk so a wrong write mask shows up.
  always_comb begin
    logic [16:0] sum;
    sum       = {1'b0, alu_b} + {1'b0, dr};
    alu_z     = junk_z;
    alu_e_out = junk_e;
    case (int'(alu_func))
      F_AND:    begin alu_z = alu_b & dr;            alu_e_out = ~alu_e_in; end
      F_ADD:    begin alu_z = sum[15:0];             alu_e_out = sum[16];   end
      F_PASSDR: begin alu_z = dr;                    alu_e_out = ~alu_e_in; end
      F_CMA:    begin alu_z = ~alu_b;                alu_e_out = ~alu_e_in; end
      F_CIR:    begin alu_z = {alu_e_in, alu_b[15:1]}; alu_e_out = alu_b[0]; end
      F_CIL:    begin alu_z = {alu_b[14:0], alu_e_in}; alu_e_out = alu_b[15]; end
      F_CME:    begin alu_z = ~alu_b;                alu_e_out = ~alu_e_in; end
      F_PASSB:  begin alu_z = alu_b;                 alu_e_out = ~alu_e_in; end
      default: ;
    endcase
  end

  // Reference model: architectural effect of one command, in plain arithmetic.
  function automatic void model_cmd(input int op, input int func);
    int n;
    int d;
    d = int'(dr);
    case (op)
      0: case (func)
        F_ADD:    begin n = m_ac + d; m_ac = n % 65536; m_e = n / 65536; end
        F_CIL:    begin n = (m_ac * 2 + m_e) % 65536; m_e = m_ac / 32768; m_ac = n; end
        F_CIR:    begin n = m_ac / 2 + m_e * 32768; m_e = m_ac % 2; m_ac = n; end
        F_CMA:    m_ac = 65535 - m_ac;
        F_CME:    m_e = 1 - m_e;
        F_PASSDR: m_ac = d;
        F_AND:    m_ac = m_ac & d;
        default: ;
      endcase
      1: m_ac = (m_ac + 1) % 65536;
      2: m_ac = 0;
      default: m_e = 0;
    endcase
  endfunction

  // Drives one command and records done latency, done pulse count and cmd_ready per cycle.
  task automatic do_cmd(input int op, input int func, output int lat, output int pulses,
                        output logic [5:0] rdy);
    int t;
    lat = -1; pulses = 0; rdy = '0;
    @(negedge clk);
    junk_z = 16'($urandom); junk_e = 1'($urandom);
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_func = 4'(func);
    t = 0;
    while (!cmd_ready && t < 10) begin @(negedge clk); t++; end
    if (!cmd_ready) begin cmd_valid = 1'b0; return; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    model_cmd(op, func);
    for (int k = 0; k < 6; k++) begin
      if (cmd_done) begin pulses++; if (lat < 0) lat = k; end
      rdy[k] = cmd_ready;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_func = '0;
    dr = '0; junk_z = '0; junk_e = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ac !== 16'h0) begin bad++; $display("FAIL reset_ac got=%h want=0000", ac); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL reset_e got=%b want=0", e); end
    total++; if (alu_func !== 4'hF) begin bad++; $display("FAIL reset_func got=%h want=f", alu_func); end
    total++; if (cmd_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", cmd_done); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", parity_err); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL ready_in_rst got=%b want=0", cmd_ready); end
    rst = 1'b0; #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ready_after_rst got=%b want=1", cmd_ready); end
    m_ac = 0; m_e = 0;
  endtask

  task automatic test_inc_wrap();
    int lat, p; logic [5:0] r;
    dr = 16'hFFFF;
    do_cmd(0, F_PASSDR, lat, p, r);
    total++; if (ac !== 16'hFFFF) begin bad++; $display("FAIL passdr_ffff got=%h want=ffff", ac); end
    do_cmd(1, 0, lat, p, r);
    total++; if (ac !== 16'h0000) begin bad++; $display("FAIL inc_wrap_ac got=%h want=0000", ac); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL inc_wrap_e got=%b want=0", e); end
    total++; if (ac_zero !== 1'b1) begin bad++; $display("FAIL inc_wrap_zero got=%b want=1", ac_zero); end
    total++; if (lat !== 0) begin bad++; $display("FAIL inc_latency got=%0d want=0", lat); end
    total++; if (p !== 1) begin bad++; $display("FAIL inc_pulses got=%0d want=1", p); end
  endtask

  task automatic test_add_carry();
    int lat, p; logic [5:0] r;
    dr = 16'h8000;
    do_cmd(0, F_PASSDR, lat, p, r);
    do_cmd(0, F_ADD, lat, p, r);
    total++; if (ac !== 16'h0000) begin bad++; $display("FAIL add_ac got=%h want=0000", ac); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL add_e got=%b want=1", e); end
    total++; if (e_zero !== 1'b0) begin bad++; $display("FAIL add_ezero got=%b want=0", e_zero); end
    total++; if (lat !== 2) begin bad++; $display("FAIL add_latency got=%0d want=2", lat); end
    total++; if (r !== 6'b111100) begin bad++; $display("FAIL add_ready got=%b want=111100", r); end
  endtask

  task automatic test_cme_cil();
    int lat, p; logic [5:0] r;
    do_cmd(3, 0, lat, p, r);
    dr = 16'h1234;
    do_cmd(0, F_PASSDR, lat, p, r);
    do_cmd(0, F_CME, lat, p, r);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL cme_e got=%b want=1", e); end
    total++; if (ac !== 16'h1234) begin bad++; $display("FAIL cme_ac got=%h want=1234", ac); end
    do_cmd(0, F_CIL, lat, p, r);
    total++; if (ac !== 16'h2469) begin bad++; $display("FAIL cil_ac got=%h want=2469", ac); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL cil_e got=%b want=0", e); end
  endtask

  task automatic test_nofunc();
    int lat, p; logic [5:0] r;
    dr = 16'h00AA;
    do_cmd(0, F_PASSDR, lat, p, r);
    dr = 16'h5555;
    do_cmd(0, F_NO_FUNC, lat, p, r);
    total++; if (ac !== 16'h00AA) begin bad++; $display("FAIL nofunc_ac got=%h want=00aa", ac); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL nofunc_e got=%b want=0", e); end
    total++; if (p !== 1) begin bad++; $display("FAIL nofunc_pulses got=%0d want=1", p); end
    total++; if (lat !== 2) begin bad++; $display("FAIL nofunc_latency got=%0d want=2", lat); end
  endtask

  task automatic test_random();
    int lat, p, op, func; logic [5:0] r;
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 3));
      func = int'($urandom_range(0, 15));
      dr = 16'($urandom);
      do_cmd(op, func, lat, p, r);
      total++; if (ac !== 16'(m_ac)) begin bad++; $display("FAIL rnd_ac i=%0d op=%0d f=%0d got=%h want=%h", i, op, func, ac, 16'(m_ac)); end
      total++; if (e !== 1'(m_e)) begin bad++; $display("FAIL rnd_e i=%0d op=%0d f=%0d got=%b want=%0d", i, op, func, e, m_e); end
      total++; if ({ac_zero, ac_neg, e_zero} !== {m_ac == 0, m_ac >= 32768, m_e == 0}) begin
        bad++; $display("FAIL rnd_flags i=%0d got=%b%b%b ac=%0d e=%0d", i, ac_zero, ac_neg, e_zero, m_ac, m_e);
      end
      total++; if (lat !== ((op == 0) ? 2 : 0)) begin bad++; $display("FAIL rnd_latency i=%0d op=%0d got=%0d", i, op, lat); end
      total++; if (p !== 1) begin bad++; $display("FAIL rnd_pulses i=%0d got=%0d want=1", i, p); end
      total++; if (r !== ((op == 0) ? 6'b111100 : 6'b111111)) begin bad++; $display("FAIL rnd_ready i=%0d op=%0d got=%b", i, op, r); end
      total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL rnd_perr i=%0d got=%b want=0", i, parity_err); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, p; logic [5:0] r;
    dr = 16'h00F0;
    do_cmd(0, F_PASSDR, lat, p, r);
    do_cmd(0, F_CME, lat, p, r);
    @(negedge clk);
    junk_z = 16'hDEAD; junk_e = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_func = 4'(F_ADD);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ac = 0; m_e = 0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", cmd_ready); end
    p = 0;
    for (int k = 0; k < 5; k++) begin
      if (cmd_done) p++;
      @(posedge clk); #1;
    end
    total++; if (p !== 0) begin bad++; $display("FAIL midrst_done got=%0d want=0", p); end
    total++; if (ac !== 16'h0) begin bad++; $display("FAIL midrst_ac got=%h want=0000", ac); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL midrst_e got=%b want=0", e); end
  endtask

`ifdef AC_PARITY_EN
  task automatic test_parity();
    int lat, p; logic [5:0] r;
    dr = 16'h0001;
    do_cmd(0, F_PASSDR, lat, p, r);
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_clean got=%b want=0", parity_err); end
    @(negedge clk);
    force dut.ac_q = 16'h0005;
    @(posedge clk); #1;
    total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_detect got=%b want=1", parity_err); end
    release dut.ac_q;
    do_cmd(2, 0, lat, p, r);
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_clear got=%b want=0", parity_err); end
    total++; if (ac !== 16'h0) begin bad++; $display("FAIL par_clr_ac got=%h want=0000", ac); end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_inc_wrap();
    test_add_carry();
    test_cme_cil();
    test_nofunc();
    test_random();
    test_reset_mid();
`ifdef AC_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mano_ac_unit.md
Name: mano_ac_unit

Overview:
- Accumulator/E-flag stage directly downstream of the Mano ALU.
- Owns the AC and E registers. Feeds AC and E back to the ALU as b/e_in and drives the ALU function code.
- Captures the ALU z/e_out under a write mask derived from the function, and performs AC-local ops (INC, CLR).
- Exposes AC-state flags to the control sequencer for the SPA/SNA/SZA/SZE skip decisions.

Parameters:
- DATAWIDTH, 16, width of AC, DR, ALU operands (matches `datawidth).
- FUNCWIDTH, 4, width of ALU function code (matches `funcwidth).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  sequencer presents a command.
- cmd_ready  out  1  unit can accept a command (high only in IDLE).
- cmd_op  in  2  0=ALU_WB, 1=INC_AC, 2=CLR_AC, 3=CLR_E.
- cmd_func  in  FUNCWIDTH  ALU function for ALU_WB (CIL/CIR/CMA/CME/PASSB/PASSDR/AND/ADD/NO_FUNC).
- cmd_done  out  1  one-cycle pulse when the command's writeback has completed.
- alu_func  out  FUNCWIDTH  registered function driven to the ALU.
- alu_b  out  DATAWIDTH  current AC (ALU b input).
- alu_e_in  out  1  current E (ALU e_in).
- alu_z  in  DATAWIDTH  ALU result.
- alu_e_out  in  1  ALU carry/E result.
- ac  out  DATAWIDTH  AC register value.
- e  out  1  E register value.
- ac_zero  out  1  AC == 0.
- ac_neg  out  1  AC[DATAWIDTH-1].
- e_zero  out  1  E == 0.
- parity_err  out  1  AC integrity fault (see Optional Feature).

Behaviour:
- Reset (rst=1 at edge): AC=0, E=0, alu_func=NO_FUNC, state=IDLE, cmd_done=0, parity_err=0. Reset mid-command aborts it; no writeback occurs.
- Handshake: command accepted on an edge where cmd_valid && cmd_ready. cmd_ready = (state==IDLE) && !rst. cmd_* sampled only at acceptance.
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE + accept ALU_WB: alu_func <= cmd_func; go to ISSUE.
- IDLE + accept INC_AC / CLR_AC / CLR_E: execute in the same edge; cmd_done=1 next cycle; stay IDLE.
- ISSUE: alu_func held stable for one full cycle so the combinational ALU settles; go to CAPTURE.
- CAPTURE: apply write mask; cmd_done=1 during the following cycle; alu_func <= NO_FUNC; go to IDLE.
- Latency: ALU_WB accepted at edge T, AC/E updated at edge T+2, cmd_done high in cycle after T+2. Local ops: updated at T, done in cycle after T.
- cmd_ready stays low throughout ISSUE/CAPTURE. A second command is accepted no earlier than the edge after CAPTURE.
- Write mask:
  - CIL, CIR, ADD: AC<=alu_z, E<=alu_e_out.
  - CMA, PASSB, PASSDR, AND: AC only.
  - CME: E only.
  - NO_FUNC or any undefined code: neither written; cmd_done still pulses.
- INC_AC: AC<=AC+1 modulo 2^DATAWIDTH (0xFFFF -> 0x0000); E unchanged.
- CLR_AC: AC<=0. CLR_E: E<=0.
- alu_b, alu_e_in, ac, e are direct register outputs. Flags are combinational from registers and valid every cycle.

Optional Feature:
- Macro: AC_PARITY_EN.
- Defined: an extra parity register stores the even parity of every value written to AC (reset value 0, matching AC=0). Each cycle the parity of AC is recomputed and compared with the stored bit. On mismatch, parity_err is set and stays sticky until rst or CLR_AC.
- Not defined: no parity register; parity_err tied to 0.

Test Plan:
- Reset then INC_AC with AC=0xFFFF preloaded via PASSDR (DR=0xFFFF) -> AC=0x0000, E unchanged (0), ac_zero=1, done one cycle after accept.
- ALU_WB ADD with AC=0x8000, DR=0x8000, E=0 -> at T+2 AC=0x0000, E=1, e_zero=0, cmd_ready low for cycles T+1..T+2.
- ALU_WB CME with E=0, AC=0x1234 -> E=1, AC stays 0x1234. Then CIL -> AC=0x2469, E=0.
- ALU_WB NO_FUNC with AC=0x00AA -> AC and E unchanged, cmd_done pulses once.
- Assert rst during ISSUE of ADD -> AC=0, E=0, no done pulse, cmd_ready=1 the cycle after reset deasserts.
- With AC_PARITY_EN: force AC bit flip via testbench after PASSDR 0x0001 -> parity_err=1 next cycle, cleared by CLR_AC.
